// File: rtl/uart_ram_loader.sv
// UART-driven RAM loader: receives 8N1 bytes, parses an 0xA5 + 24-bit LEN frame,
// and writes little-endian 32-bit words to consecutive word addresses.
module uart_ram_loader #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CLK_RATE  = 6_250_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned RAM_DEPTH = 100_000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rxd,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] wdata,
  output logic             enw,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned DIV = (CLK_RATE + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV) + 1;
  localparam int unsigned IW  = $clog2(RAM_DEPTH) + 1;
  localparam int unsigned LW  = 24;

  typedef enum logic [1:0] {RIDLE, START, RDATA, STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, LEN2, DATA, WRITE, FAIL} fr_state_t;

  // rxd synchroniser plus one extra stage for falling-edge detection
  logic rxd_m, rxd_s, rxd_p;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  rx_state_t      rx_q, rx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     rx_byte, shift_d;
  logic           byte_valid, byte_valid_d;
  logic           frame_err, frame_err_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_q       <= RIDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      rx_byte    <= shift_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // Receiver: start bit checked at half a bit, data and stop one bit apart
  always_comb begin
    rx_d         = rx_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = rx_byte;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_q)
      RIDLE: begin
        cnt_d = '0;
        if (rxd_p && !rxd_s) rx_d = START;
      end
      START: begin
        if (cnt_q == CW'(DIV / 2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rxd_s ? RIDLE : RDATA;
        end
      end
      RDATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rxd_s, rx_byte[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          rx_d  = RIDLE;
          if (rxd_s) byte_valid_d = 1'b1;
          else       frame_err_d  = 1'b1;
        end
      end
      default: rx_d = RIDLE;
    endcase
  end

  fr_state_t      fs_q, fs_d;
  logic [LW-1:0]  len_q, len_d, len_full;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] word_q, word_d, addr_d, wdata_d;
  logic [1:0]     bcnt_q, bcnt_d;
  logic           enw_d, busy_d, done_d, error_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fs_q    <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      address <= '0;
      wdata   <= '0;
      enw     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      fs_q    <= fs_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      address <= addr_d;
      wdata   <= wdata_d;
      enw     <= enw_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

  // Frame parser; enw/address/wdata are registered so they appear together in WRITE
  always_comb begin
    fs_d     = fs_q;
    len_d    = len_q;
    idx_d    = idx_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    addr_d   = address;
    wdata_d  = wdata;
    enw_d    = 1'b0;
    busy_d   = busy;
    done_d   = done;
    error_d  = error;
    len_full = {rx_byte, len_q[15:0]};
    case (fs_q)
      IDLE, FAIL: begin
        if (byte_valid && rx_byte == 8'hA5) begin
          fs_d    = LEN0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      LEN0: if (byte_valid) begin len_d[7:0]  = rx_byte; fs_d = LEN1; end
      LEN1: if (byte_valid) begin len_d[15:8] = rx_byte; fs_d = LEN2; end
      LEN2: begin
        if (byte_valid) begin
          len_d = len_full;
          if (len_full == '0) begin
            fs_d   = IDLE;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else if (32'(len_full) > RAM_DEPTH) begin
            fs_d    = FAIL;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            fs_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          word_d = {rx_byte, word_q[WIDTH-1:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            fs_d    = WRITE;
            enw_d   = 1'b1;
            addr_d  = WIDTH'({idx_q, 2'b00});
            wdata_d = {rx_byte, word_q[WIDTH-1:8]};
          end
        end
      end
      WRITE: begin
        idx_d = idx_q + IW'(1);
        if (LW'(idx_q) + LW'(1) == len_q) begin
          fs_d   = IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          fs_d = DATA;
        end
      end
      default: fs_d = IDLE;
    endcase
    if (frame_err && fs_q != IDLE) begin
      fs_d    = FAIL;
      error_d = 1'b1;
      busy_d  = 1'b0;
      enw_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader: serial frames driven at 54 clk/bit,
// RAM writes captured by a monitor and compared to hand-computed values.
module tb_uart_ram_loader;

  localparam int unsigned BIT = 54;

  logic        clk = 1'b0;
  logic        nrst;
  logic        rxd;
  logic [31:0] address, wdata;
  logic        enw, busy, done, error;

  int checks = 0;
  int failures = 0;

  uart_ram_loader dut (
    .clk(clk), .nrst(nrst), .rxd(rxd),
    .address(address), .wdata(wdata), .enw(enw),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // write and byte monitors
  logic [31:0] wa [32];
  logic [31:0] wd [32];
  int nw = 0;
  int nb = 0;
  logic [7:0] last_b = '0;
  int byte_cyc = 0;
  int done_rise = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (enw) begin
      if (nw < 32) begin
        wa[nw] = address;
        wd[nw] = wdata;
      end
      nw++;
    end
    if (dut.byte_valid) begin
      nb++;
      last_b = dut.rx_byte;
      byte_cyc = cyc;
    end
    if (done && !done_prev) done_rise = cyc;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int t0;
  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(posedge clk);
    rxd = 1'b0;
    t0 = cyc;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    rxd = stop_ok;
    repeat (BIT) @(posedge clk);
    rxd = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  logic [7:0] fr2 [12] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] fr1 [8]  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] fr3 [16] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                           8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_addr"},  address, 32'h0);
    check({pfx, "_wdata"}, wdata,   32'h0);
    check({pfx, "_enw"},   32'(enw),   32'h0);
    check({pfx, "_busy"},  32'(busy),  32'h0);
    check({pfx, "_done"},  32'(done),  32'h0);
    check({pfx, "_error"}, 32'(error), 32'h0);
  endtask

  int n0, b0, lat;

  initial begin
    nrst = 1'b0;
    rxd  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    nrst = 1'b1;
    repeat (5) @(posedge clk);

    // single byte, no header
    b0 = nb;
    send_byte(8'h5A);
    lat = byte_cyc - t0;
    check("byte_count", 32'(nb - b0), 32'd1);
    check("byte_value", 32'(last_b), 32'h5A);
    check("byte_latency_ok", 32'(lat >= 500 && lat <= 530), 32'd1);
    check("byte_no_enw", 32'(nw), 32'd0);
    check("byte_busy", 32'(busy), 32'd0);

    // two-word frame
    n0 = nw;
    for (int i = 0; i < 4; i++) send_byte(fr2[i]);
    check("f2_busy_mid", 32'(busy), 32'd1);
    check("f2_done_mid", 32'(done), 32'd0);
    for (int i = 4; i < 12; i++) send_byte(fr2[i]);
    check("f2_enw_count", 32'(nw - n0), 32'd2);
    check("f2_addr0",  wa[n0],     32'h0);
    check("f2_wdata0", wd[n0],     32'h44332211);
    check("f2_addr1",  wa[n0 + 1], 32'h4);
    check("f2_wdata1", wd[n0 + 1], 32'h88776655);
    check("f2_done", 32'(done), 32'd1);
    check("f2_busy", 32'(busy), 32'd0);
    check("f2_error", 32'(error), 32'd0);

    // zero-length frame
    n0 = nw;
    send_byte(8'hA5);
    check("f0_done_cleared", 32'(done), 32'd0);
    check("f0_busy_set", 32'(busy), 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("f0_done", 32'(done), 32'd1);
    check("f0_busy", 32'(busy), 32'd0);
    check("f0_done_latency", 32'(done_rise - byte_cyc), 32'd1);
    check("f0_no_enw", 32'(nw - n0), 32'd0);

    // oversize length 100001
    n0 = nw;
    send_byte(8'hA5);
    send_byte(8'hA1);
    send_byte(8'h86);
    send_byte(8'h01);
    check("big_error", 32'(error), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    for (int i = 4; i < 8; i++) send_byte(fr2[i]);
    check("big_no_enw", 32'(nw - n0), 32'd0);
    check("big_error_held", 32'(error), 32'd1);

    // framing error on 3rd data byte, then a good frame
    n0 = nw;
    for (int i = 0; i < 12; i++) send_byte(fr2[i], i != 6);
    check("ferr_error", 32'(error), 32'd1);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_no_enw", 32'(nw - n0), 32'd0);
    for (int i = 0; i < 8; i++) send_byte(fr1[i]);
    check("recover_error", 32'(error), 32'd0);
    check("recover_done", 32'(done), 32'd1);
    check("recover_enw_count", 32'(nw - n0), 32'd1);
    check("recover_addr", wa[n0], 32'h0);
    check("recover_wdata", wd[n0], 32'hEFBEADDE);

    // 10-cycle glitch
    b0 = nb;
    @(posedge clk);
    rxd = 1'b0;
    repeat (10) @(posedge clk);
    rxd = 1'b1;
    repeat (1000) @(posedge clk);
    check("glitch_no_byte", 32'(nb - b0), 32'd0);

    // reset after first write of a 3-word frame
    n0 = nw;
    for (int i = 0; i < 8; i++) send_byte(fr3[i]);
    check("rst_first_write", 32'(nw - n0), 32'd1);
    check("rst_first_wdata", wd[n0], 32'h04030201);
    #3;
    nrst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    nrst = 1'b1;
    for (int i = 8; i < 16; i++) send_byte(fr3[i]);
    check("rst_no_more_writes", 32'(nw - n0), 32'd1);
    check("rst_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
